// File: rtl/alu_core.sv
// alu_core_pkg / alu_core
//
// Purpose: 32-bit integer ALU for the RV32I execute stage. It covers add,
// subtract, signed and unsigned set-less-than, the three shifts and bitwise
// XOR/OR/AND. The result and the condition flags are registered once per
// clock, so the unit has a latency of one cycle and accepts a new operation
// every cycle. There is no handshake.
//
// Ports:
//   clk_i          in   1   clock, all state on rising edge
//   reset_n_i      in   1   asynchronous active-low reset, clears all outputs
//   a_i            in   32  operand A (rs1 / PC)
//   b_i            in   32  operand B (rs2 / immediate)
//   ctrl_alu_op_i  in   4   operation select, encoded as control_alu_op_e
//   result_o       out  32  registered result
//   Z_o            out  1   result == 0
//   N_o            out  1   result[31]
//   S_o            out  1   signed a_i < signed b_i (independent of the op)
//   C_o            out  1   adder carry-out for ADD/SUB/SLT/SLTU, else 0
//   V_o            out  1   adder signed overflow for ADD/SUB/SLT/SLTU, else 0

package alu_core_pkg;
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLT  = 4'd2,
    OP_SLTU = 4'd3,
    OP_SLL  = 4'd4,
    OP_SRL  = 4'd5,
    OP_SRA  = 4'd6,
    OP_XOR  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } control_alu_op_e;
endpackage

module alu_core
  import alu_core_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  ctrl_alu_op_i,
  output logic [31:0] result_o,
  output logic        Z_o,
  output logic        N_o,
  output logic        S_o,
  output logic        C_o,
  output logic        V_o
);

  logic        use_sub;
  logic [31:0] b_add;
  logic [32:0] sum;
  logic        add_c;
  logic        add_v;
  logic [4:0]  shamt;
  logic        lt_s;
  logic [31:0] res_d;
  logic        c_d;
  logic        v_d;
  logic        z_d;
  logic        n_d;

  logic [31:0] result_p0;
  logic        z_p0;
  logic        n_p0;
  logic        s_p0;
  logic        c_p0;
  logic        v_p0;

  always_comb begin
    // One shared adder. SUB, SLT and SLTU use the a + ~b + 1 form, so the
    // carry-out means "no borrow" (a >= b unsigned) for those ops.
    use_sub = (ctrl_alu_op_i == OP_SUB) || (ctrl_alu_op_i == OP_SLT) ||
              (ctrl_alu_op_i == OP_SLTU);
    b_add   = use_sub ? ~b_i : b_i;
    sum     = {1'b0, a_i} + {1'b0, b_add} + {32'd0, use_sub};
    add_c   = sum[32];
    add_v   = (a_i[31] == b_add[31]) && (sum[31] != a_i[31]);
    shamt   = b_i[4:0];
    // Branch compare helper: always reflects a - b, whatever the op.
    lt_s    = $signed(a_i) < $signed(b_i);

    res_d = 32'd0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (ctrl_alu_op_i)
      OP_ADD, OP_SUB: begin
        res_d = sum[31:0];
        c_d   = add_c;
        v_d   = add_v;
      end
      OP_SLT: begin
        res_d = {31'd0, lt_s};
        c_d   = add_c;
        v_d   = add_v;
      end
      OP_SLTU: begin
        res_d = {31'd0, ~add_c};
        c_d   = add_c;
        v_d   = add_v;
      end
      OP_SLL:  res_d = a_i << shamt;
      OP_SRL:  res_d = a_i >> shamt;
      OP_SRA:  res_d = $signed(a_i) >>> shamt;
      OP_XOR:  res_d = a_i ^ b_i;
      OP_OR:   res_d = a_i | b_i;
      OP_AND:  res_d = a_i & b_i;
      default: res_d = 32'd0;
    endcase

    z_d = (res_d == 32'd0);
    n_d = res_d[31];
  end

  // Stage p0: result and flags registered together; reset clears everything,
  // including Z, so the outputs read all-zero while reset is held.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      result_p0 <= 32'd0;
      z_p0      <= 1'b0;
      n_p0      <= 1'b0;
      s_p0      <= 1'b0;
      c_p0      <= 1'b0;
      v_p0      <= 1'b0;
    end else begin
      result_p0 <= res_d;
      z_p0      <= z_d;
      n_p0      <= n_d;
      s_p0      <= lt_s;
      c_p0      <= c_d;
      v_p0      <= v_d;
    end
  end

  assign result_o = result_p0;
  assign Z_o      = z_p0;
  assign N_o      = n_p0;
  assign S_o      = s_p0;
  assign C_o      = c_p0;
  assign V_o      = v_p0;

endmodule

// File: tb/tb_alu_core.sv
// Testbench for alu_core: directed steps, expected values from a behavioural
// model pushed to a scoreboard queue when driven and popped one cycle later.
module tb_alu_core;
  import alu_core_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [3:0]  ctrl_alu_op_i;
  logic [31:0] result_o;
  logic        Z_o, N_o, S_o, C_o, V_o;

  alu_core dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .ctrl_alu_op_i (ctrl_alu_op_i),
    .result_o      (result_o),
    .Z_o           (Z_o),
    .N_o           (N_o),
    .S_o           (S_o),
    .C_o           (C_o),
    .V_o           (V_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flags; // {Z,N,S,C,V}
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    total  = 0;
  int    passed = 0;
  int    failed = 0;

  // Behavioural model using 64-bit signed arithmetic for overflow and compare.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, r64;
    logic [63:0] wide;
    logic        c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0: begin
        e.res = a + b;
        wide  = {32'd0, a} + {32'd0, b};
        c     = wide[32];
        r64   = sa + sb;
        v     = (r64 > 64'sd2147483647) || (r64 < -64'sd2147483648);
      end
      4'd1, 4'd2, 4'd3: begin
        if (op == 4'd1) e.res = a - b;
        else if (op == 4'd2) e.res = (sa < sb) ? 32'd1 : 32'd0;
        else e.res = (a < b) ? 32'd1 : 32'd0;
        c   = (a >= b);
        r64 = sa - sb;
        v   = (r64 > 64'sd2147483647) || (r64 < -64'sd2147483648);
      end
      4'd4: e.res = a << b[4:0];
      4'd5: e.res = a >> b[4:0];
      4'd6: begin
        r64   = sa >>> b[4:0];
        e.res = r64[31:0];
      end
      4'd7: e.res = a ^ b;
      4'd8: e.res = a | b;
      4'd9: e.res = a & b;
      default: e.res = 32'd0;
    endcase
    e.flags = {(e.res == 32'd0), e.res[31], (sa < sb), c, v};
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    ctrl_alu_op_i = op;
    a_i           = a;
    b_i           = b;
    sb_q.push_back(model(op, a, b));
    tag_q.push_back(tag);
  endtask

  task automatic collect();
    exp_t  e;
    string t;
    @(posedge clk_i);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check({t, "_res"}, result_o, e.res);
      check({t, "_ZNSCV"}, {27'd0, Z_o, N_o, S_o, C_o, V_o}, {27'd0, e.flags});
    end
  endtask

  task automatic step(input string tag, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    drive(tag, op, a, b);
    collect();
  endtask

  initial begin
    reset_n_i     = 1'b0;
    a_i           = 32'd0;
    b_i           = 32'd0;
    ctrl_alu_op_i = 4'd0;
    #12;
    check("rst_res", result_o, 32'd0);
    check("rst_flags", {27'd0, Z_o, N_o, S_o, C_o, V_o}, 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    step("add",     OP_ADD,  32'd3000, 32'd1500);
    step("sub",     OP_SUB,  32'd3000, 32'd1500);
    step("slt0",    OP_SLT,  32'd3000, 32'd1500);
    step("slt1",    OP_SLT,  32'd3000, 32'd4000);
    step("sltu",    OP_SLTU, 32'd1,    32'hFFFF_FFFF);
    step("slt_neg", OP_SLT,  32'hFFFF_FFFF, 32'd1);
    step("sll",     OP_SLL,  32'hFF,   32'd4);
    step("sll_hi",  OP_SLL,  32'hFF,   32'hFFFF_FFE5);
    step("srl",     OP_SRL,  32'h8000_0000, 32'd31);
    step("sra",     OP_SRA,  32'h8000_0000, 32'd31);
    step("sra_pos", OP_SRA,  32'h4000_0000, 32'd4);
    step("sh0",     OP_SRA,  32'h8765_4321, 32'd0);
    step("xor",     OP_XOR,  32'b1001, 32'b1101);
    step("or",      OP_OR,   32'b1001, 32'b1101);
    step("and",     OP_AND,  32'b1001, 32'b1101);
    step("ovf_add", OP_ADD,  32'h7FFF_FFFF, 32'd1);
    step("wrap",    OP_ADD,  32'hFFFF_FFFF, 32'd1);
    step("ovf_sub", OP_SUB,  32'h8000_0000, 32'd1);
    step("sub_brw", OP_SUB,  32'd5,    32'd7);
    step("undef_a", 4'hA,    32'h1234_5678, 32'h1234_5678);
    step("undef_f", 4'hF,    32'h0000_0001, 32'h8000_0000);

    // Asynchronous reset asserted between edges, mid-stream.
    drive("pre_rst", OP_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    collect();
    #2;
    reset_n_i     = 1'b0;
    ctrl_alu_op_i = OP_SUB;
    a_i           = 32'd5;
    b_i           = 32'd9;
    #1;
    check("async_rst_res", result_o, 32'd0);
    check("async_rst_flags", {27'd0, Z_o, N_o, S_o, C_o, V_o}, 32'd0);
    @(posedge clk_i);
    #1;
    check("held_rst_res", result_o, 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    sb_q.push_back(model(OP_SUB, 32'd5, 32'd9));
    tag_q.push_back("post_rst");
    collect();
    step("after", OP_OR, 32'hF0F0_0000, 32'h0000_0F0F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
